// File: rtl/vga_pkg.sv
// Shared scan-state encoding, default 640x480@60 timing and total-length helpers.
package vga_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } scan_state_t;

  // Coordinate width and the largest axis total it can represent
  localparam int unsigned POS_W     = 10;
  localparam int unsigned POS_LIMIT = 1024;

  // Frame counter width
  localparam int unsigned FCNT_W = 16;

  // Default 640x480@60 timing with a 100 MHz system clock
  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam bit          DEF_SYNC_POL = 1'b0;

  function automatic int unsigned axis_total(input int unsigned active_len,
                                             input int unsigned fp_len,
                                             input int unsigned sync_len,
                                             input int unsigned bp_len);
    return active_len + fp_len + sync_len + bp_len;
  endfunction

  function automatic int unsigned h_total(input int unsigned h_active,
                                          input int unsigned h_fp,
                                          input int unsigned h_sync,
                                          input int unsigned h_bp);
    return axis_total(h_active, h_fp, h_sync, h_bp);
  endfunction

  function automatic int unsigned v_total(input int unsigned v_active,
                                          input int unsigned v_fp,
                                          input int unsigned v_sync,
                                          input int unsigned v_bp);
    return axis_total(v_active, v_fp, v_sync, v_bp);
  endfunction

endpackage

// File: rtl/vga_scan_gen_if.sv
// Scan-generator output bundle: the generator is master, the video consumers are slaves.
interface vga_scan_gen_if;

  logic                       en;
  logic                       pix_en;
  logic [vga_pkg::POS_W-1:0]  x;
  logic [vga_pkg::POS_W-1:0]  y;
  logic                       hsync;
  logic                       vsync;
  logic                       blank;
  logic                       line_start;
  logic                       frame_start;
  logic [vga_pkg::FCNT_W-1:0] frame_count;

  modport master (
    input  en,
    output pix_en, x, y, hsync, vsync, blank, line_start, frame_start, frame_count
  );

  modport slave (
    output en,
    input  pix_en, x, y, hsync, vsync, blank, line_start, frame_start, frame_count
  );

endinterface

// File: rtl/vga_scan_gen_scan_axis.sv
// One raster axis: ACTIVE/FRONT/SYNC/BACK phase FSM plus the position counter.
module scan_axis
  import vga_pkg::*;
#(
  parameter int unsigned POS_W      = 10,
  parameter int unsigned ACTIVE_LEN = 640,
  parameter int unsigned FP_LEN     = 16,
  parameter int unsigned SYNC_LEN   = 96,
  parameter int unsigned BP_LEN     = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [POS_W-1:0] pos,
  output logic             in_sync,
  output logic             in_active,
  output logic             wrap
);

  if (ACTIVE_LEN < 1 || FP_LEN < 1 || SYNC_LEN < 1 || BP_LEN < 1) begin : g_bad_len
    $error("scan_axis: every phase length must be at least 1");
  end

  if (ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN > (1 << POS_W)) begin : g_bad_total
    $error("scan_axis: axis total does not fit in POS_W bits");
  end

  // Last in-phase count of each phase
  localparam logic [POS_W-1:0] ACTIVE_LAST = POS_W'(ACTIVE_LEN - 1);
  localparam logic [POS_W-1:0] FP_LAST     = POS_W'(FP_LEN - 1);
  localparam logic [POS_W-1:0] SYNC_LAST   = POS_W'(SYNC_LEN - 1);
  localparam logic [POS_W-1:0] BP_LAST     = POS_W'(BP_LEN - 1);

  scan_state_t      state_q, state_d, next_phase;
  logic [POS_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] phase_last;
  logic             in_sync_q, in_sync_d;
  logic             in_active_q, in_active_d;

  // Length and successor of the phase currently running
  always_comb begin
    phase_last = ACTIVE_LAST;
    next_phase = FRONT;
    unique case (state_q)
      ACTIVE: begin
        phase_last = ACTIVE_LAST;
        next_phase = FRONT;
      end
      FRONT: begin
        phase_last = FP_LAST;
        next_phase = SYNC;
      end
      SYNC: begin
        phase_last = SYNC_LAST;
        next_phase = BACK;
      end
      BACK: begin
        phase_last = BP_LAST;
        next_phase = ACTIVE;
      end
    endcase
  end

  // Last position of the axis is the last count of the back porch
  assign wrap = (state_q == BACK) && (cnt_q == BP_LAST);

  // Step phase counter and position on each advance; phase flags follow the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    if (advance) begin
      if (cnt_q == phase_last) begin
        state_d = next_phase;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      pos_d = wrap ? '0 : pos_q + 1'b1;
    end
    in_sync_d   = (state_d == SYNC);
    in_active_d = (state_d == ACTIVE);
  end

  // Axis state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACTIVE;
      cnt_q       <= '0;
      pos_q       <= '0;
      in_sync_q   <= 1'b0;
      in_active_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      in_sync_q   <= in_sync_d;
      in_active_q <= in_active_d;
    end
  end

  assign pos       = pos_q;
  assign in_sync   = in_sync_q;
  assign in_active = in_active_q;

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel-rate divider, horizontal/vertical axes, strobes and frame counter.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = DEF_SYNC_POL
) (
  input  logic           clk,
  input  logic           rst,
  vga_scan_gen_if.master scan
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_scan_gen: CLK_DIV must be in 1..16");
  end

  if (H_TOTAL > POS_LIMIT || V_TOTAL > POS_LIMIT) begin : g_bad_total
    $error("vga_scan_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0]        div_q, div_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              pix_tick;
  logic              v_advance;
  logic [POS_W-1:0]  x_pos, y_pos;
  logic              h_in_sync, v_in_sync;
  logic              h_in_active, v_in_active;
  logic              h_wrap, v_wrap;

  // Pixel strobe on the last divider phase; suppressed while frozen or in reset
  assign pix_tick  = scan.en && !rst && (div_q == DIV_LAST);
  assign v_advance = pix_tick && h_wrap;

  // Divider phase and frame counter next-state
  always_comb begin
    div_d       = div_q;
    frame_cnt_d = frame_cnt_q;
    if (scan.en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 4'd1;
    end
    if (v_advance && v_wrap) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  // Divider and frame counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      div_q       <= div_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  scan_axis #(
    .POS_W      (POS_W),
    .ACTIVE_LEN (H_ACTIVE),
    .FP_LEN     (H_FP),
    .SYNC_LEN   (H_SYNC),
    .BP_LEN     (H_BP)
  ) u_h_axis (
    .clk       (clk),
    .rst       (rst),
    .advance   (pix_tick),
    .pos       (x_pos),
    .in_sync   (h_in_sync),
    .in_active (h_in_active),
    .wrap      (h_wrap)
  );

  scan_axis #(
    .POS_W      (POS_W),
    .ACTIVE_LEN (V_ACTIVE),
    .FP_LEN     (V_FP),
    .SYNC_LEN   (V_SYNC),
    .BP_LEN     (V_BP)
  ) u_v_axis (
    .clk       (clk),
    .rst       (rst),
    .advance   (v_advance),
    .pos       (y_pos),
    .in_sync   (v_in_sync),
    .in_active (v_in_active),
    .wrap      (v_wrap)
  );

  assign scan.pix_en      = pix_tick;
  assign scan.x           = x_pos;
  assign scan.y           = y_pos;
  assign scan.hsync       = SYNC_POL ? h_in_sync : !h_in_sync;
  assign scan.vsync       = SYNC_POL ? v_in_sync : !v_in_sync;
  assign scan.blank       = !(h_in_active && v_in_active);
  assign scan.line_start  = pix_tick && (x_pos == '0);
  assign scan.frame_start = pix_tick && (x_pos == '0) && (y_pos == '0);
  assign scan.frame_count = frame_cnt_q;

endmodule
